// File: rtl/hazard_unit_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard unit.
//   FWD_*    : forwarding-select encodings for the E-stage ALU source muxes
//   REG_ZERO : hard-wired zero register, never a hazard source
//   m_state_t/w_state_t : per-stage shadow of destination register and control
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // E->M payload: everything the hazard logic needs from an instruction in M
  typedef struct packed {
    logic [REG_W-1:0] writereg;
    logic             regwrite;
    logic             memtoreg;
  } m_state_t;

  // M->W payload: a load in W is already forwardable, so memtoreg is not kept
  typedef struct packed {
    logic [REG_W-1:0] writereg;
    logic             regwrite;
  } w_state_t;

  // E-stage source select; M has priority over W, $0 never forwards
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                               input m_state_t       m,
                                               input w_state_t       w);
    logic [FWD_W-1:0] sel;
    sel = FWD_NONE;
    if (src != REG_ZERO && src == m.writereg && m.regwrite)
      sel = FWD_MEM;
    else if (src != REG_ZERO && src == w.writereg && w.regwrite)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_pipe_if.sv
// Bundle between controller/datapath (master) and the hazard unit (slave).
//   master drives register specifiers, E/D control bits and clr_cnt;
//   slave returns forwarding selects, stall/flush controls and perf counters.
interface hazard_unit_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  import mips_pipe_pkg::*;

  logic [REG_W-1:0] rsD;
  logic [REG_W-1:0] rtD;
  logic [REG_W-1:0] rsE;
  logic [REG_W-1:0] rtE;
  logic [REG_W-1:0] writeregE;
  logic             regwriteE;
  logic             memtoregE;
  logic             branchD;
  logic             pcsrcD;
  logic             clr_cnt;

  logic             forwardAD;
  logic             forwardBD;
  logic [FWD_W-1:0] forwardAE;
  logic [FWD_W-1:0] forwardBE;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, regwriteE, memtoregE,
           branchD, pcsrcD, clr_cnt,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, flushD, flushE, stall_cnt, flush_cnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, regwriteE, memtoregE,
           branchD, pcsrcD, clr_cnt,
    output forwardAD, forwardBD, forwardAE, forwardBE,
           stallF, stallD, flushD, flushE, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_stage_tracker.sv
// Shadow of the E->M->W destination-register/control pipeline.
//   clk, rst_n : clock, async active-low reset
//   i_e        : E-stage writereg/regwrite/memtoreg
//   o_m, o_w   : registered M and W copies
// No enable: E/M/W never stall, bubbles arrive as regwrite=0.
module hazard_stage_tracker
  import mips_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  m_state_t i_e,
  output m_state_t o_m,
  output w_state_t o_w
);

  m_state_t r_m;
  w_state_t r_w;

  // E->M->W shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_m <= i_e;
      r_w <= '{writereg: r_m.writereg, regwrite: r_m.regwrite};
    end
  end

  assign o_m = r_m;
  assign o_w = r_w;

endmodule

// File: rtl/hazard_unit_pipe.sv
// Hazard detection and forwarding unit for the 5-stage MIPS pipeline.
//   clk, reset : clock, async active-low reset
//   hz (slave) : D/E specifiers and control in; forward selects, stallF/D,
//                flushD/E and saturating stall/flush counters out.
// Forward/stall/flush outputs are combinational with zero latency.
module hazard_unit_pipe
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_pipe_if.slave hz
);

  m_state_t         w_e;
  m_state_t         w_m;
  w_state_t         w_w;
  logic             w_regwriteM;
  logic             w_memtoregM;
  logic             w_regwriteW;
  logic [REG_W-1:0] w_writeregM;
  logic             w_lwstall;
  logic             w_branchstall;
  logic             w_stall;
  logic             w_flushD;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_e = '{writereg: hz.writeregE, regwrite: hz.regwriteE,
                 memtoreg: hz.memtoregE};

  hazard_stage_tracker u_tracker (
    .clk   (clk),
    .rst_n (reset),
    .i_e   (w_e),
    .o_m   (w_m),
    .o_w   (w_w)
  );

  assign w_regwriteM = w_m.regwrite;
  assign w_memtoregM = w_m.memtoreg;
  assign w_writeregM = w_m.writereg;
  assign w_regwriteW = w_w.regwrite;

  // E-stage ALU source forwarding
  assign hz.forwardAE = fwd_sel(hz.rsE, w_m, w_w);
  assign hz.forwardBE = fwd_sel(hz.rtE, w_m, w_w);

  // M-to-D forwarding for the branch comparator; W is covered by the
  // register file writing in the first half-cycle
  assign hz.forwardAD = (hz.rsD != REG_ZERO) && (hz.rsD == w_writeregM) && w_regwriteM;
  assign hz.forwardBD = (hz.rtD != REG_ZERO) && (hz.rtD == w_writeregM) && w_regwriteM;

  // Load in E feeding the instruction in D
  assign w_lwstall = hz.memtoregE && hz.regwriteE && (hz.writeregE != REG_ZERO) &&
                     ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));

  // Branch in D needs an operand that is still in the ALU (E) or the load unit (M)
  assign w_branchstall = hz.branchD &&
    ((hz.regwriteE && (hz.writeregE != REG_ZERO) &&
      ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
     (w_memtoregM && (w_writeregM != REG_ZERO) &&
      ((w_writeregM == hz.rsD) || (w_writeregM == hz.rtD))));

  assign w_stall = w_lwstall || w_branchstall;

  // A stall means the branch outcome is not valid yet, so it wins over pcsrcD
  assign w_flushD = hz.pcsrcD && !w_stall;

  assign hz.stallF = w_stall;
  assign hz.stallD = w_stall;
  assign hz.flushE = w_stall;
  assign hz.flushD = w_flushD;

  // Saturating performance counters; clr_cnt overrides an increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (hz.clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flushD && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_pipe.sv
// Directed bench for hazard_unit_pipe: forwarding, load-use and branch stalls,
// flush priority, counter saturation/clear and asynchronous reset.
module tb_hazard_unit_pipe;
  import mips_pipe_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  // Controller-side view of the M/W control copies
  logic [4:0] m_wrM;
  logic       m_rwM;
  logic       m_mtM;
  logic [4:0] m_wrW;
  logic       m_rwW;

  hazard_unit_pipe_if #(.CNT_W(CNT_W)) hif ();

  hazard_unit_pipe #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    check({tag, ".stallF"}, 32'(hif.stallF), 32'(exp));
    check({tag, ".stallD"}, 32'(hif.stallD), 32'(exp));
    check({tag, ".flushE"}, 32'(hif.flushE), 32'(exp));
  endtask

  task automatic e_stage(input logic [4:0] wr, input logic rw, input logic mt,
                         input logic [4:0] rs, input logic [4:0] rt);
    hif.writeregE = wr;
    hif.regwriteE = rw;
    hif.memtoregE = mt;
    hif.rsE       = rs;
    hif.rtE       = rt;
  endtask

  task automatic d_stage(input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic pc);
    hif.rsD     = rs;
    hif.rtD     = rt;
    hif.branchD = br;
    hif.pcsrcD  = pc;
  endtask

  // One clock; updates the controller model and optionally checks the tracker
  task automatic cyc(input bit inv);
    @(posedge clk);
    if (reset) begin
      m_wrW = m_wrM;
      m_rwW = m_rwM;
      m_wrM = hif.writeregE;
      m_rwM = hif.regwriteE;
      m_mtM = hif.memtoregE;
    end
    #1;
    if (inv) begin
      check("inv.regwriteM", 32'(dut.w_regwriteM), 32'(m_rwM));
      check("inv.memtoregM", 32'(dut.w_memtoregM), 32'(m_mtM));
      check("inv.regwriteW", 32'(dut.w_regwriteW), 32'(m_rwW));
    end
  endtask

  task automatic model_clear();
    m_wrM = '0; m_rwM = 1'b0; m_mtM = 1'b0; m_wrW = '0; m_rwW = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    reset = 1'b0;
    hif.clr_cnt = 1'b0;
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    d_stage(5'd0, 5'd0, 1'b0, 1'b0);
    #2;

    // Reset state
    check("rst.forwardAE", 32'(hif.forwardAE), 32'(FWD_NONE));
    check("rst.forwardBE", 32'(hif.forwardBE), 32'(FWD_NONE));
    check("rst.forwardAD", 32'(hif.forwardAD), 32'd0);
    chk_stall("rst", 1'b0);
    check("rst.flushD", 32'(hif.flushD), 32'd0);
    check("rst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("rst.flush_cnt", 32'(hif.flush_cnt), 32'd0);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);

    // add $2 in E; sub rs=$2 next; or rs=rt=$2 after that
    e_stage(5'd2, 1'b1, 1'b0, 5'd0, 5'd0);
    cyc(1'b1);
    e_stage(5'd4, 1'b1, 1'b0, 5'd2, 5'd0);
    #1;
    check("fwd.sub.AE", 32'(hif.forwardAE), 32'(FWD_MEM));
    check("fwd.sub.BE", 32'(hif.forwardBE), 32'(FWD_NONE));
    chk_stall("fwd.sub", 1'b0);
    cyc(1'b1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd2, 5'd2);
    #1;
    check("fwd.wb.AE", 32'(hif.forwardAE), 32'(FWD_WB));
    check("fwd.wb.BE", 32'(hif.forwardBE), 32'(FWD_WB));
    cyc(1'b1);

    // Same register in M and W: M wins
    e_stage(5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
    cyc(1'b1);
    e_stage(5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
    cyc(1'b1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd6, 5'd0);
    #1;
    check("fwd.prio.AE", 32'(hif.forwardAE), 32'(FWD_MEM));
    cyc(1'b1);

    // lw $3 in E, rtD=$3: one stall cycle, then forward from W
    e_stage(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
    d_stage(5'd0, 5'd3, 1'b0, 1'b0);
    #1;
    chk_stall("lw.use", 1'b1);
    check("lw.cnt_pre", 32'(hif.stall_cnt), 32'd0);
    cyc(1'b1);
    check("lw.cnt_post", 32'(hif.stall_cnt), 32'd1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    chk_stall("lw.bubble", 1'b0);
    cyc(1'b1);
    e_stage(5'd9, 1'b1, 1'b0, 5'd0, 5'd3);
    d_stage(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("lw.fwdBE", 32'(hif.forwardBE), 32'(FWD_WB));
    cyc(1'b1);

    // beq rsD=$5 while E writes $5 via ALU: one stall, then forwardAD
    e_stage(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    d_stage(5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    chk_stall("br.alu", 1'b1);
    cyc(1'b1);
    check("br.alu.cnt", 32'(hif.stall_cnt), 32'd2);
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    chk_stall("br.alu.res", 1'b0);
    check("br.alu.fwdAD", 32'(hif.forwardAD), 32'd1);
    check("br.alu.fwdBD", 32'(hif.forwardBD), 32'd0);
    cyc(1'b1);

    // beq rtD=$5 behind lw $5: two stall cycles
    e_stage(5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
    d_stage(5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    chk_stall("br.lw1", 1'b1);
    cyc(1'b1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    chk_stall("br.lw2", 1'b1);
    cyc(1'b1);
    #1;
    chk_stall("br.lw.res", 1'b0);
    check("br.lw.cnt", 32'(hif.stall_cnt), 32'd4);

    // $0 destination never forwards or stalls
    e_stage(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
    d_stage(5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    chk_stall("zero.e", 1'b0);
    cyc(1'b1);
    #1;
    check("zero.AE", 32'(hif.forwardAE), 32'(FWD_NONE));
    check("zero.BE", 32'(hif.forwardBE), 32'(FWD_NONE));
    check("zero.AD", 32'(hif.forwardAD), 32'd0);
    check("zero.BD", 32'(hif.forwardBD), 32'd0);
    chk_stall("zero.m", 1'b0);

    // Taken branch under stall: no flush; resolved next cycle: flush
    e_stage(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    d_stage(5'd7, 5'd0, 1'b1, 1'b1);
    #1;
    chk_stall("fl.stall", 1'b1);
    check("fl.flushD0", 32'(hif.flushD), 32'd0);
    cyc(1'b1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    check("fl.flushD1", 32'(hif.flushD), 32'd1);
    check("fl.cnt_pre", 32'(hif.flush_cnt), 32'd0);
    cyc(1'b1);
    check("fl.cnt_post", 32'(hif.flush_cnt), 32'd1);
    check("fl.stall_cnt", 32'(hif.stall_cnt), 32'd5);
    d_stage(5'd0, 5'd0, 1'b0, 1'b0);

    // Hold a load-use stall past saturation
    e_stage(5'd8, 1'b1, 1'b1, 5'd8, 5'd0);
    d_stage(5'd8, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc(1'b0);
    cyc(1'b1);
    check("sat.stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
    check("sat.flush_cnt", 32'(hif.flush_cnt), 32'd1);
    check("sat.fwdAE", 32'(hif.forwardAE), 32'(FWD_MEM));

    // clr_cnt beats the concurrent increment
    hif.clr_cnt = 1'b1;
    cyc(1'b1);
    check("clr.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("clr.flush_cnt", 32'(hif.flush_cnt), 32'd0);
    hif.clr_cnt = 1'b0;
    cyc(1'b1);
    check("clr.resume", 32'(hif.stall_cnt), 32'd1);

    // Asynchronous reset mid-stall
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("arst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("arst.regwriteM", 32'(dut.w_regwriteM), 32'd0);
    check("arst.memtoregM", 32'(dut.w_memtoregM), 32'd0);
    check("arst.regwriteW", 32'(dut.w_regwriteW), 32'd0);
    check("arst.fwdAE", 32'(hif.forwardAE), 32'(FWD_NONE));
    chk_stall("arst.e_live", 1'b1);
    e_stage(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    chk_stall("arst.e_clear", 1'b0);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);
    check("arst.post_cnt", 32'(hif.stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_pipe.md
Name: hazard_unit_pipe

Overview:
Hazard and forwarding unit for the 5-stage pipelined MIPS core. It consumes the E-stage control bits and branchD from the pipelined controller, plus register specifiers from the datapath. It produces the forwarding selects, stall and flush signals, and flushE, which feeds back into the controller's decode-to-execute register. It keeps its own M/W copies of destination-register and control state, and maintains stall/flush performance counters.

Parameters:
CNT_W, 16, width of each performance counter (saturating)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rsD  in  5  rs specifier, decode stage
rtD  in  5  rt specifier, decode stage
rsE  in  5  rs specifier, execute stage
rtE  in  5  rt specifier, execute stage
writeregE  in  5  destination register after regdst mux, execute stage
regwriteE  in  1  from controller, E stage
memtoregE  in  1  from controller, E stage
branchD  in  1  from controller, D stage
pcsrcD  in  1  branch taken, D stage
clr_cnt  in  1  synchronous counter clear
forwardAD  out  1  forward ALUoutM to rs comparator in D
forwardBD  out  1  forward ALUoutM to rt comparator in D
forwardAE  out  2  srcA select, E stage
forwardBE  out  2  srcB select, E stage
stallF  out  1  hold PC
stallD  out  1  hold IF/ID register
flushD  out  1  clear IF/ID register
flushE  out  1  clear ID/EX register (to controller and datapath)
stall_cnt  out  CNT_W  cycles with stallD=1
flush_cnt  out  CNT_W  cycles with flushD=1

Behaviour:
- Internal tracker: on each rising clk, writeregM<=writeregE, regwriteM<=regwriteE, memtoregM<=memtoregE; then W copies take the M values. No enable, because the E/M/W stages never stall. flushE bubbles arrive as regwriteE=0 from the controller.
- Reset (reset=0, asynchronous): tracker registers and both counters go to 0. All combinational outputs then evaluate to 0 given zero inputs.
- forwardAE (and forwardBE, using rtE): 2'b10 (FWD_MEM) if rsE!=0 & rsE==writeregM & regwriteM. Otherwise 2'b01 (FWD_WB) if rsE!=0 & rsE==writeregW & regwriteW. Otherwise 2'b00 (FWD_NONE). The M stage has priority.
- forwardAD = rsD!=0 & rsD==writeregM & regwriteM. forwardBD is the same using rtD. No W-to-D forwarding: the register file writes in the first half-cycle.
- lwstall = memtoregE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- branchstall = branchD & writeregX!=0 & ((regwriteE & (writeregE==rsD|writeregE==rtD)) | (memtoregM & (writeregM==rsD|writeregM==rtD))). Here writeregX is the respective stage's destination register.
- stallF = stallD = flushE = lwstall | branchstall. All are combinational, with zero added latency.
- flushD = pcsrcD & ~stallD. A stall dominates a taken branch, because the branch outcome is not yet valid.
- Counters: increment by 1 on each clk where stallD (resp. flushD) is 1. Each saturates at all-ones with no wrap. clr_cnt=1 forces 0 on the next edge and overrides an increment in the same cycle.
- Register $0 never causes forwarding or stalls.
- The tracker's regwriteM/memtoregM/regwriteW must match the controller's M/W copies cycle-for-cycle. The bench checks this as an invariant.
- Reset asserted mid-stall clears the tracker immediately. The stall drops as soon as the E inputs permit.

Decomposition:
- mips_pipe_pkg holds the forwarding-select constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and REG_ZERO=5'd0.
- One sub-module, hazard_stage_tracker, holds the E-to-M-to-W shadow registers for writereg, regwrite and memtoreg, with asynchronous active-low reset.
- Top level: combinational forward/stall logic plus the two saturating counters.

Test Plan:
- add $2 in E, then sub using rs=$2 next cycle -> forwardAE=2'b10 for 1 cycle; two cycles later a dependent op gets forwardAE=2'b01.
- lw $3 in E (memtoregE=1, writeregE=3), rtD=3 -> stallF=stallD=flushE=1 for exactly 1 cycle; stall_cnt increments by 1; the next cycle shows forwardBE=2'b01.
- beq in D with rsD=5 while E writes $5 (ALU op) -> 1-cycle stall; then forwardAD=1 when $5 reaches M. With lw $5 in E -> 2 stall cycles.
- writeregE=0 with regwriteE=1, rsD=rsE=0 -> all forward selects 0, no stall.
- pcsrcD=1 with branchstall=1 -> flushD=0; the next cycle, with the stall resolved and pcsrcD=1 -> flushD=1, flush_cnt=1.
- Force stallD high for 2^CNT_W+3 cycles -> stall_cnt holds all-ones. Then clr_cnt=1 together with stall -> 0. Then assert reset=0 mid-stall -> counters and tracker read 0 asynchronously.
